seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 103 ++++++++++
 tb/tb_seq_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and step-counter sizing.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the
// already-shifted partial remainder and select the result.
module div_step #(
  parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] dvs_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // part_rem < 2*dvs_mag, so the difference fits WIDTH+1 bits and its MSB is the borrow
  always_comb begin
    diff     = part_rem - {1'b0, dvs_mag};
    q_bit    = ~diff[WIDTH];
    next_rem = q_bit ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned restoring divider: one quotient bit per cycle,
// fixed latency, sign correction in a final FIX cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (({rem, dq[WIDTH-1]})),
    .dvs_mag  (dvs),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // dq starts as the dividend magnitude and fills with quotient bits as it shifts out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            neg_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op & dividend[WIDTH-1];
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              cnt         <= '0;
              rem         <= '0;
              dq          <= mag(dividend, signed_op);
              dvs         <= mag(divisor, signed_op);
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          rem <= step_rem;
          dq  <= {dq[WIDTH-2:0], step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= neg_q ? -dq : dq;
          remainder <= neg_r ? -rem : rem;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic start_op(input logic sop, input logic [31:0] a, input logic [31:0] b);
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; optionally pulses a
  // stray start after edge inj (0 = none).
  task automatic wait_done(input logic exp_busy, input int inj, output int edges);
    int bad_busy;
    bad_busy = 0;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (busy !== exp_busy) bad_busy++;
      if (inj != 0 && edges == inj) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 edges++;
    end
    start = 1'b0;
    check("busy_during_op", 32'(bad_busy), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic sop, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_z, input int inj);
    int edges;
    start_op(sop, a, b);
    wait_done(exp_lat != 0, inj, edges);
    check({tag, "_lat"}, 32'(edges), 32'(exp_lat));
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_z});
  endtask

  // One cycle after done: pulse must have ended, results must hold.
  task automatic after_done(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
    @(posedge clk);
    #1;
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_hold_q"}, quotient, exp_q);
    check({tag, "_hold_r"}, remainder, exp_r);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 0);
    after_done("u100_7", 32'd14, 32'd2);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
    run_div("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE, 1'b0, 0);
    run_div("u7_100", 1'b0, 32'd7, 32'd100, 33, 32'd0, 32'd7, 1'b0, 0);
    run_div("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    run_div("u80_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0);
    run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 0);
    after_done("sovf", 32'h8000_0000, 32'd0);

    run_div("u5_0", 1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    after_done("u5_0", 32'hFFFF_FFFF, 32'd5);
    check("dbz_hold", {31'd0, div_by_zero}, 32'd1);
    run_div("s5_0", 1'b1, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, 0);

    // Stray start mid-CALC is ignored; start in DONE runs back-to-back.
    run_div("inj", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 10);
    run_div("b2b", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, 1'b0, 0);
    after_done("b2b", 32'd3, 32'd0);

    // Asynchronous reset in the middle of CALC.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_div("post_rst", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    after_done("post_rst", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
